// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// Shared memory-port arbiter for instruction fetch and data access: round-robin grant,
// req/ack sequencing towards the backing memory, ready/stall generation and a timeout watchdog.
module mem_port_arbiter #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       TIMEOUT  = 16,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ready_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ready_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              stall_if_o,
  output logic              stall_mem_o,
  output logic              err_o
);

  localparam int unsigned CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              dm_ready_q, dm_ready_d;
  logic              err_q, err_d;

  logic if_elig, dm_elig, busy_data, finish, abort;

  // A side that is being answered this cycle must not be re-granted on its still-high request.
  assign if_elig   = if_req_i & ~if_ready_q;
  assign dm_elig   = dm_req_i & ~dm_ready_q;
  assign busy_data = (state_q == BUSY_D);
  assign finish    = (state_q != IDLE) & mem_ack_i;
  assign abort     = (state_q != IDLE) & ~mem_ack_i & (cnt_q == CNT_LAST);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    if_ready_d   = 1'b0;
    dm_ready_d   = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      IDLE: begin
        // On a tie the side opposite the previous grant wins.
        if (dm_elig && (!if_elig || !last_grant_q)) begin
          state_d      = BUSY_D;
          last_grant_d = 1'b1;
          cnt_d        = '0;
          mem_req_d    = 1'b1;
          mem_we_d     = dm_we_i;
          mem_addr_d   = dm_addr_i;
          mem_wdata_d  = dm_wdata_i;
        end else if (if_elig) begin
          state_d      = BUSY_I;
          last_grant_d = 1'b0;
          cnt_d        = '0;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr_i;
          mem_wdata_d  = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (finish || abort) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          err_d     = abort;
          if (busy_data) begin
            dm_ready_d = 1'b1;
            if (!mem_we_q) dm_rdata_d = finish ? mem_rdata_i : ERR_DATA;
          end else begin
            if_ready_d = 1'b1;
            if_rdata_d = finish ? mem_rdata_i : ERR_DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      if_ready_q   <= 1'b0;
      dm_ready_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      if_ready_q   <= if_ready_d;
      dm_ready_q   <= dm_ready_d;
      err_q        <= err_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign if_ready_o  = if_ready_q;
  assign dm_ready_o  = dm_ready_q;
  assign err_o       = err_q;
  assign stall_if_o  = if_req_i & ~if_ready_q;
  assign stall_mem_o = dm_req_i & ~dm_ready_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for one shared, variable-latency memory port used by both instruction fetch and the data-memory stage of the 5-stage MIPS pipeline. It serializes fetch and load/store requests and drives a req/ack handshake to the backing memory. It returns read data and per-side one-cycle ready pulses, and produces stall signals for the pipeline. A watchdog aborts transactions the memory never acknowledges.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 16, cycles without mem_ack before abort (≥2)
- ERR_DATA, 32'hDEAD_BEEF, read data returned on abort

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- if_req  in  1  fetch request, level, held until if_ready
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction, registered
- if_ready  out  1  one-cycle pulse, fetch done
- dm_req  in  1  data request, level, held until dm_ready
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data, registered
- dm_ready  out  1  one-cycle pulse, data access done
- mem_req  out  1  backing-memory request, registered
- mem_we  out  1  backing-memory write enable
- mem_addr  out  ADDR_W  backing-memory address
- mem_wdata  out  DATA_W  backing-memory write data
- mem_rdata  in  DATA_W  backing-memory read data, valid with mem_ack
- mem_ack  in  1  one-cycle acknowledge
- stall_if  out  1  fetch pending: if_req & ~if_ready
- stall_mem  out  1  data pending: dm_req & ~dm_ready
- err  out  1  one-cycle pulse on timeout abort

## Operation
- States: IDLE, BUSY_I, BUSY_D. Internal registers: last_grant (0 = fetch, 1 = data) and a timeout counter.
- IDLE grant rules:
  - Only dm_req high → BUSY_D. Only if_req high → BUSY_I.
  - Both high → grant the side opposite last_grant (round-robin). last_grant resets to fetch, so data wins the first tie.
  - A side whose ready is high in the current cycle is not eligible, so a req still high in the ready cycle is ignored.
- On grant: latch addr, and for data also we and wdata, into mem_addr/mem_we/mem_wdata. Set mem_req=1, clear the counter, update last_grant.
  - Fetch grants always drive mem_we=0 and mem_wdata=0.
- In BUSY_*: mem_req and all mem_* outputs are held stable. The counter increments each cycle mem_ack is 0.
- mem_ack sampled 1 in BUSY_*:
  - mem_req→0, mem_we→0, state→IDLE.
  - Pulse the granted side's ready.
  - Load or fetch: the rdata register captures mem_rdata. Store: dm_rdata is unchanged.
- Timeout: the counter reaches TIMEOUT-1 with mem_ack still 0.
  - Drop mem_req, go to IDLE, pulse err and the granted side's ready.
  - Load/fetch: rdata ← ERR_DATA.
- Ignored inputs:
  - mem_ack in IDLE, including a late ack after an abort.
  - Requests arriving during BUSY_* wait for IDLE.
- stall_if and stall_mem are combinational from req and the registered ready.

## Timing
- Reset (asserted at any time, including mid-transaction) immediately forces, without waiting for clk:
  - State IDLE, last_grant fetch, counter 0.
  - mem_req, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata, if_ready, dm_ready, err all 0.
  - An in-flight transaction is dropped; no ready pulse follows.
- Zero-wait memory (acks in the first cycle mem_req is high):
  - Edge 0 grants.
  - mem_req is high in cycle 0→1 and ack is sampled at edge 1.
  - ready is high in cycle 1→2.
  - The next grant is possible at edge 2.
  - Throughput: one access per 2 cycles. Each memory wait state adds one cycle.
- Timeout with no ack: err/ready pulse after edge TIMEOUT counted from the grant edge.
- Simultaneous mem_ack and counter reaching its limit: the ack wins, with no err.
- Back-to-back requests with both sides pending alternate D, I, D, I…

## Test plan
- Single load, zero-wait memory, dm_addr=0x40, mem_rdata=0x1234_5678 → mem_req high 1 cycle, mem_addr=0x40, mem_we=0; dm_ready pulses 2 cycles after request; dm_rdata=0x1234_5678; stall_mem high for exactly those 2 cycles.
- Both sides requesting from reset, memory with 2 wait states → grant order D, I, D, I; each access 4 cycles; if_rdata/dm_rdata match the memory model; a store returns dm_ready with dm_rdata unchanged.
- Store, dm_we=1, dm_addr=0x80, dm_wdata=0xCAFE_F00D, ack after 3 cycles → mem_we=1 and addr/wdata stable all 4 cycles mem_req is high; dm_ready pulses once.
- Memory never acks a fetch, TIMEOUT=16 → mem_req drops after 16 cycles; err and if_ready pulse together; if_rdata=0xDEAD_BEEF. An ack injected 3 cycles later is ignored, with no extra ready.
- Reset asserted mid-BUSY_D → all outputs 0 immediately. After release, pending if_req is granted first: IDLE, last_grant fetch, and only fetch requesting.
- mem_ack coincident with the counter reaching TIMEOUT-1 → normal completion, err=0, rdata = mem_rdata.
